// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: menu-cursor geometry, colour, FSM states
// and the frame hit test used by the cursor stage.
package vga_pkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned RGB_W = 12;

  localparam logic [CNT_W-1:0] BOX_X  = 11'd222;
  localparam logic [CNT_W-1:0] BOX_Y0 = 11'd260;
  localparam logic [CNT_W-1:0] BOX_W  = 11'd476;
  localparam logic [CNT_W-1:0] BOX_H  = 11'd60;
  localparam logic [CNT_W-1:0] PITCH  = 11'd80;
  localparam logic [CNT_W-1:0] BORDER = 11'd4;

  localparam logic [RGB_W-1:0] CURSOR_RGB = 12'hfff;

  typedef enum logic [1:0] {CUR_IDLE, CUR_ACTIVE, CUR_CONFIRM, CUR_HOLD} cursor_state_t;

  // True on the BORDER-thick ring of the frame around option idx
  function automatic logic in_frame(input logic [CNT_W-1:0] h,
                                    input logic [CNT_W-1:0] v,
                                    input logic [1:0]       idx);
    logic [CNT_W-1:0] y0;
    logic             outer;
    logic             inner;
    y0    = BOX_Y0 + CNT_W'(idx) * PITCH;
    outer = (v >= y0) && (v <= y0 + BOX_H - 11'd1) &&
            (h >= BOX_X) && (h <= BOX_X + BOX_W - 11'd1);
    inner = (v >= y0 + BORDER) && (v <= y0 + BOX_H - BORDER - 11'd1) &&
            (h >= BOX_X + BORDER) && (h <= BOX_X + BOX_W - BORDER - 11'd1);
    return outer && !inner;
  endfunction

endpackage

// File: rtl/vga_if.sv
// VGA pixel-stream bundle passed between draw stages.
interface vga_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] vcount;
  logic [CNT_W-1:0] hcount;
  logic             vsync;
  logic             hsync;
  logic             vblnk;
  logic             hblnk;
  logic [RGB_W-1:0] rgb;

  modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
  modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/btn_edge.sv
// Per-bit rising-edge detector; the history is registered, the pulse is not.
module btn_edge #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] rise_c
);

  logic [W-1:0] prev;

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= '0;
    else        prev <= din;
  end

  assign rise_c = din & ~prev;

endmodule

// File: rtl/draw_menu_cursor.sv
// Menu cursor overlay: blinking frame around the highlighted option, moved by
// up/down presses, confirmed by select. Registered pass-through otherwise.
module draw_menu_cursor
  import vga_pkg::*;
#(
  parameter logic [2:0]  MENU_STATE   = 3'd0,
  parameter int unsigned N_OPT        = 3,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] state,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_sel,
  output logic [1:0] sel_idx,
  output logic       sel_valid,
  vga_if.in          vga_cur_in,
  vga_if.out         vga_cur_out
);

  localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
  localparam logic [1:0]         LAST_IDX   = 2'(N_OPT - 1);

  cursor_state_t      fsm;
  logic [BLINK_W-1:0] blink_cnt;
  logic               blink_on;
  logic [2:0]         btn_rise_c;
  logic               frame_tick_c;
  logic               up_p_c;
  logic               dn_p_c;
  logic               sel_p_c;
  logic               menu_c;
  logic               draw_c;
  logic               show_c;

  btn_edge #(.W(3)) u_btn_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    ({btn_sel, btn_down, btn_up}),
    .rise_c (btn_rise_c)
  );

  btn_edge #(.W(1)) u_vblnk_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (vga_cur_in.vblnk),
    .rise_c (frame_tick_c)
  );

  assign up_p_c  = btn_rise_c[0];
  assign dn_p_c  = btn_rise_c[1];
  assign sel_p_c = btn_rise_c[2];
  assign menu_c  = (state == MENU_STATE);
  assign draw_c  = in_frame(vga_cur_in.hcount, vga_cur_in.vcount, sel_idx);
  assign show_c  = draw_c && (((fsm == CUR_ACTIVE) && blink_on) || (fsm == CUR_HOLD));

  // Cursor FSM with blink timer; later assignments to the blink regs win
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm       <= CUR_IDLE;
      sel_idx   <= 2'd0;
      sel_valid <= 1'b0;
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else begin
      sel_valid <= 1'b0;

      if (fsm == CUR_IDLE) begin
        blink_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (frame_tick_c) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          blink_cnt <= blink_cnt + BLINK_W'(1);
        end
      end

      case (fsm)
        CUR_IDLE: begin
          if (menu_c) begin
            fsm     <= CUR_ACTIVE;
            sel_idx <= 2'd0;
          end
        end
        CUR_ACTIVE: begin
          if (!menu_c) begin
            fsm <= CUR_IDLE;
          end else if (sel_p_c) begin
            fsm       <= CUR_CONFIRM;
            sel_valid <= 1'b1;
          end else if (up_p_c ^ dn_p_c) begin
            if (up_p_c) sel_idx <= (sel_idx == 2'd0) ? LAST_IDX : sel_idx - 2'd1;
            else        sel_idx <= (sel_idx == LAST_IDX) ? 2'd0 : sel_idx + 2'd1;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
          end
        end
        CUR_CONFIRM: fsm <= menu_c ? CUR_HOLD : CUR_IDLE;
        CUR_HOLD:    if (!menu_c) fsm <= CUR_IDLE;
        default:     fsm <= CUR_IDLE;
      endcase
    end
  end

  // One-cycle video stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_cur_out.vcount <= '0;
      vga_cur_out.hcount <= '0;
      vga_cur_out.vsync  <= 1'b0;
      vga_cur_out.hsync  <= 1'b0;
      vga_cur_out.vblnk  <= 1'b0;
      vga_cur_out.hblnk  <= 1'b0;
      vga_cur_out.rgb    <= '0;
    end else begin
      vga_cur_out.vcount <= vga_cur_in.vcount;
      vga_cur_out.hcount <= vga_cur_in.hcount;
      vga_cur_out.vsync  <= vga_cur_in.vsync;
      vga_cur_out.hsync  <= vga_cur_in.hsync;
      vga_cur_out.vblnk  <= vga_cur_in.vblnk;
      vga_cur_out.hblnk  <= vga_cur_in.hblnk;
      vga_cur_out.rgb    <= show_c ? CURSOR_RGB : vga_cur_in.rgb;
    end
  end

endmodule

// File: doc/draw_menu_cursor.md
Name: draw_menu_cursor

Overview:
- Stage directly downstream of the menu-title draw stage in the VGA pixel chain.
- While the game FSM is in the menu state, it overlays a blinking rectangular frame around one of N_OPT stacked menu options.
- The frame moves with up/down button presses; a select press reports the chosen option to the game FSM.
- In all other states it is a registered pass-through.

Parameters:
- MENU_STATE, 3'd0, value of state that enables the cursor.
- N_OPT, 3, number of selectable options (2..4).
- BOX_X, 222, left edge of every option frame in pixels.
- BOX_Y0, 260, top edge of option 0 frame.
- BOX_W, 476, frame outer width.
- BOX_H, 60, frame outer height.
- PITCH, 80, vertical distance between consecutive option frames.
- BORDER, 4, frame line thickness.
- BLINK_FRAMES, 30, frames per blink half-period.
- CURSOR_RGB, 12'hf_f_f, frame colour.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  synchronous reset, active-low.
- state  in  3  game FSM state.
- btn_up  in  1  level, already synchronised/debounced.
- btn_down  in  1  level, already synchronised/debounced.
- btn_sel  in  1  level, already synchronised/debounced.
- sel_idx  out  2  registered index of highlighted option.
- sel_valid  out  1  one-cycle pulse: sel_idx confirmed.
- vga_cur_in  vga_if.in  bundle  vcount/hcount 11b, vsync/hsync/vblnk/hblnk 1b, rgb 12b from menu stage.
- vga_cur_out  vga_if.out  bundle  same fields, to next stage.

Behaviour:
Clocking and reset:
- One clock domain, clk.
- Reset is synchronous, active-low on rst_n; applied when rst_n=0 at a clk edge.
- Reset values: all vga_cur_out fields 0, sel_idx 0, sel_valid 0, blink_on 1, blink counter 0, FSM IDLE, button history registers 0.

Video path:
- Latency is exactly 1 clk on every vga field, matching the other draw stages.
- Sync, blank and count fields are copied unchanged.
- Draw condition: vcount in [y0, y0+BOX_H-1] and hcount in [BOX_X, BOX_X+BOX_W-1], but not inside the inner rectangle inset by BORDER on all sides.
  - y0 = BOX_Y0 + sel_idx*PITCH.
  - Compare in 11-bit unsigned.
- rgb_out = CURSOR_RGB when FSM=ACTIVE, the draw condition holds and blink_on=1.
- rgb_out = CURSOR_RGB when FSM=HOLD and the draw condition holds; the frame is steady in HOLD.
- Otherwise rgb_out = rgb_in.

Edge detection and frame tick:
- up_p, dn_p and sel_p are each 1 for one cycle on a 0->1 transition of the corresponding button.
- frame_tick = rising edge of vga_cur_in.vblnk.

Blink:
- On frame_tick, the counter increments.
- At BLINK_FRAMES-1 the counter wraps to 0 and blink_on toggles.
- Counter and blink_on are held at reset values while FSM=IDLE.

FSM:
- IDLE
  - state==MENU_STATE -> ACTIVE, sel_idx<=0, blink restarts.
- ACTIVE
  - state!=MENU_STATE -> IDLE.
  - else sel_p -> CONFIRM. sel_p has priority over up_p/dn_p in the same cycle; no move occurs.
  - else up_p && dn_p -> no move.
  - else up_p -> sel_idx-1, wrapping 0 -> N_OPT-1.
  - else dn_p -> sel_idx+1, wrapping N_OPT-1 -> 0.
  - Any move sets blink counter=0 and blink_on=1, so the frame is immediately visible.
- CONFIRM
  - sel_valid=1 for exactly this one cycle; sel_idx is frozen.
  - Next state is HOLD.
  - If state!=MENU_STATE in this cycle, the pulse is still emitted and the next state is IDLE.
- HOLD
  - Buttons are ignored; sel_idx is frozen.
  - state!=MENU_STATE -> IDLE.

Other boundary conditions:
- A button held through IDLE -> ACTIVE does not count as a press unless a fresh 0->1 edge occurs.
- rst_n low mid-frame or mid-CONFIRM: all outputs take reset values on that edge; no sel_valid pulse.

Decomposition:
- vga_pkg gains:
  - the cursor geometry/colour localparams (BOX_*, PITCH, BORDER, CURSOR_RGB);
  - the typedef enum logic [1:0] {CUR_IDLE, CUR_ACTIVE, CUR_CONFIRM, CUR_HOLD} cursor_state_t.
- Natural sub-module: btn_edge (per-bit registered rising-edge detector, width parameter). It is instantiated once for the 3 buttons and once for vblnk.

Test Plan:
- Reset: rst_n=0 for 3 clks with random inputs -> all vga_cur_out fields 0, sel_idx=0, sel_valid=0; after release, vga_cur_out equals vga_cur_in delayed 1 clk while state=1.
- Enter menu (state=0), no buttons -> pixel (hcount=222, vcount=260) gets rgb fff for 30 frames, then passes rgb_in for 30 frames; inner pixel (300,290) is always rgb_in.
- btn_down pressed 3 times with N_OPT=3 -> sel_idx 1, 2, 0. Frame top moves to vcount 340, then 420, then 260, and the frame is visible on the frame after each press.
- btn_up from sel_idx=0 -> sel_idx=2. Simultaneous up+down rising edges -> sel_idx unchanged.
- btn_sel with sel_idx=1 -> sel_valid high exactly 1 clk with sel_idx=1. Then up/down presses are ignored and the frame is steady. state=2 -> overlay gone, FSM IDLE. Re-entering state 0 -> sel_idx=0.
- btn_sel and btn_down rising in the same cycle -> sel_valid pulse with the old sel_idx. Also: rst_n asserted during CONFIRM -> no pulse, and outputs go to reset values.
